pipe_scroll_controller: RTL and testbench
=========================================

// Module: pipe_scroll_controller
// PURPOSE
//  Sequences the 40-bit pipe shift register that scrolls obstacles across the screen.
//  Generates the column shift strobe at a speed-selectable rate and the serial column bit.
//  Column pattern: PIPE_W ones (pipe), then SPACING zeros (open sky).
//  Draws a new pseudo-random gap height for each pipe and flushes the register on every new game.
// PARAMETERS
//  REG_LEN    40          length of the driven shift register (flush count)
//  DIV_BASE   1250000     clk cycles per shift at speed_sel=0 (40 Hz @ 50 MHz)
//  PIPE_W     4           consecutive 1-columns per pipe
//  SPACING    12          consecutive 0-columns between pipes
//  GAP_MIN    10          minimum gap_y value
//  LFSR_SEED  8'hA5       LFSR reset value (must be non-zero)
// PORTS
//  clk         in   1   system clock
//  resetn      in   1   asynchronous, active-low reset
//  start       in   1   level; rising edge requests a new game
//  pause       in   1   level; holds scrolling while high
//  game_over   in   1   level; collision detected, freezes scrolling
//  speed_sel   in   2   shift period = DIV_BASE >> speed_sel
//  shift_en    out  1   one-cycle strobe: shift register takes shift_data
//  shift_data  out  1   column bit presented with shift_en (1 = pipe)
//  gap_y       out  7   gap height of the pipe being emitted (GAP_MIN + lfsr[5:0])
//  gap_valid   out  1   one-cycle pulse when gap_y updates (first column of each pipe)
//  running     out  1   high in RUN state
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE; all outputs 0; divider=0; col_cnt=0; lfsr=LFSR_SEED.
//  - All outputs are registered; shift_en and gap_valid are high for exactly 1 cycle.
//  - States:
//    - IDLE: wait for start rising edge -> FLUSH.
//    - FLUSH: REG_LEN consecutive cycles with shift_en=1, shift_data=0 (no divider) -> RUN.
//    - RUN: divider counts 0..period-1; at terminal count emit shift_en with the pattern bit.
//      pause=1 -> PAUSED; game_over=1 -> HALT.
//    - PAUSED: divider and pattern counters hold; pause=0 -> RUN, resuming mid-period.
//    - HALT: no strobes; outputs hold; start rising edge -> FLUSH.
//  - Priority within one cycle: game_over > pause > tick. A tick coinciding with game_over is
//    dropped. game_over is ignored in IDLE and FLUSH.
//  - Pattern: col_cnt runs 0..PIPE_W+SPACING-1, wrapping to 0. shift_data = (col_cnt < PIPE_W).
//    col_cnt advances only on RUN strobes.
//  - Gap: at each strobe with col_cnt==0, first step the LFSR, then load
//    gap_y = GAP_MIN + new lfsr[5:0] and pulse gap_valid together with shift_en.
//  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, shift-left, feedback into bit0.
//  - Entering FLUSH clears col_cnt and divider; lfsr is not reseeded. The first RUN strobe
//    therefore starts a pipe.
//  - Period is sampled at divider reload. A speed_sel change mid-period applies on the next
//    period, except when divider >= new period: then the tick fires on the next cycle.
//  - start edge detect uses a registered copy of start. Edges in RUN and PAUSED are ignored.
//  - Divider width: $clog2(DIV_BASE). Period arithmetic is unsigned; DIV_BASE>>3 must be >= 2.
// STRUCTURE
//  - Shared package/include (game_pkg.vh): state encodings (IDLE, FLUSH, RUN, PAUSED, HALT),
//    REG_LEN, and the LFSR tap constant.
//  - One sub-module, lfsr8 (clk, resetn, step, seed, q[7:0]), reused by other random sources.
//  - Divider, pattern counter and FSM stay inline.
// TESTING (bench with DIV_BASE=16, PIPE_W=2, SPACING=3, GAP_MIN=10)
//  1. Reset then start pulse -> 40 back-to-back strobes with data 0, running=1 next cycle.
//  2. RUN, speed_sel=0 -> strobes 16 clk apart; data 1,1,0,0,0,1,1...;
//     gap_valid on the 1st and 6th strobes.
//  3. speed_sel=2 mid-run -> spacing becomes 4 cycles from the next reload; gap_y in [10,73].
//  4. pause for 100 cycles at divider=7 -> no strobes; after release, next strobe 9 cycles later.
//  5. game_over on a tick cycle -> no strobe, running=0, outputs hold; start -> flush restarts.
//  6. resetn low mid-FLUSH -> outputs 0 immediately (async); lfsr=A5 after release.

Source files
------------

// File: rtl/pipe_scroll_controller_pkg.sv
// Shared definitions for the pipe scroller: FSM encodings, flush length and LFSR tap mask.
package pipe_scroll_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam int PIPE_REG_LEN = 40;

    // Taps 8,6,5,4 of a shift-left Fibonacci LFSR, as a mask over bits [7:0].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/pipe_scroll_controller_lfsr8.sv
// 8-bit Fibonacci LFSR that advances one step whenever step is high; reset loads seed.
module lfsr8
    import pipe_scroll_controller_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_scroll_controller.sv
// Drives the obstacle shift register: flush on new game, then a speed-selectable column
// strobe carrying a pipe/sky pattern, with a fresh random gap height per pipe.
module pipe_scroll_controller
    import pipe_scroll_controller_pkg::*;
#(
    parameter int         REG_LEN   = PIPE_REG_LEN,
    parameter int         DIV_BASE  = 1250000,
    parameter int         PIPE_W    = 4,
    parameter int         SPACING   = 12,
    parameter int         GAP_MIN   = 10,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       pause,
    input  logic       game_over,
    input  logic [1:0] speed_sel,
    output logic       shift_en,
    output logic       shift_data,
    output logic [6:0] gap_y,
    output logic       gap_valid,
    output logic       running
);

    localparam int DIV_W = $clog2(DIV_BASE);
    localparam int PER_W = DIV_W + 1;
    localparam int COLS  = PIPE_W + SPACING;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FL_W  = (REG_LEN > 1) ? $clog2(REG_LEN) : 1;

    state_e             state_q, state_d;
    logic               start_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   term_q, term_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [FL_W-1:0]    flush_q, flush_d;
    logic               shift_en_q, shift_en_d;
    logic               shift_data_q, shift_data_d;
    logic [6:0]         gap_y_q, gap_y_d;
    logic               gap_valid_q, gap_valid_d;
    logic               running_q, running_d;

    logic               start_rise;
    logic [PER_W-1:0]   live_per;
    logic [DIV_W-1:0]   live_term;
    logic               tick_cond;
    logic               active;
    logic               tick;
    logic               lfsr_step;
    logic [7:0]         lfsr_q;
    logic [7:0]         lfsr_nx;
    logic [7:0]         gap_src;

    lfsr8 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .step   (lfsr_step),
        .seed   (LFSR_SEED),
        .q      (lfsr_q)
    );

    assign start_rise = start & ~start_q;
    assign live_per   = PER_W'(DIV_BASE) >> speed_sel;
    assign live_term  = DIV_W'(live_per - PER_W'(1));
    // A speed-up that leaves the divider already past the new period fires immediately.
    assign tick_cond  = (div_q == term_q) || ({1'b0, div_q} >= live_per);
    assign active     = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) && !game_over && !pause;
    assign tick       = active && tick_cond;
    assign lfsr_nx    = lfsr_next(lfsr_q);
    assign gap_src    = lfsr_nx & 8'h3F;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_rise) state_d = ST_FLUSH;
            ST_FLUSH:  if (flush_q == FL_W'(REG_LEN - 1)) state_d = ST_RUN;
            ST_RUN: begin
                if (game_over) begin
                    state_d = ST_HALT;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (game_over) begin
                    state_d = ST_HALT;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT:   if (start_rise) state_d = ST_FLUSH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Divider, column and flush counters; the period is only re-sampled at reload.
    always_comb begin
        div_d     = div_q;
        term_d    = term_q;
        col_d     = col_q;
        flush_d   = flush_q;
        lfsr_step = 1'b0;
        if ((state_q != ST_RUN) && (state_q != ST_PAUSED)) begin
            term_d = live_term;
        end
        if (state_d == ST_FLUSH) begin
            if (state_q == ST_FLUSH) begin
                flush_d = flush_q + FL_W'(1);
            end else begin
                div_d   = '0;
                col_d   = '0;
                flush_d = '0;
            end
        end else if (tick) begin
            div_d     = '0;
            term_d    = live_term;
            col_d     = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
            lfsr_step = (col_q == '0);
        end else if (active) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_comb begin
        shift_en_d   = (state_d == ST_FLUSH) || tick;
        shift_data_d = shift_data_q;
        if (state_d == ST_FLUSH) begin
            shift_data_d = 1'b0;
        end else if (tick) begin
            shift_data_d = (col_q < COL_W'(PIPE_W));
        end
        gap_valid_d = tick && (col_q == '0);
        gap_y_d     = gap_valid_d ? 7'(8'(GAP_MIN) + gap_src) : gap_y_q;
        running_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_q      <= 1'b0;
            div_q        <= '0;
            term_q       <= '0;
            col_q        <= '0;
            flush_q      <= '0;
            shift_en_q   <= 1'b0;
            shift_data_q <= 1'b0;
            gap_y_q      <= '0;
            gap_valid_q  <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            start_q      <= start;
            div_q        <= div_d;
            term_q       <= term_d;
            col_q        <= col_d;
            flush_q      <= flush_d;
            shift_en_q   <= shift_en_d;
            shift_data_q <= shift_data_d;
            gap_y_q      <= gap_y_d;
            gap_valid_q  <= gap_valid_d;
            running_q    <= running_d;
        end
    end

    assign shift_en   = shift_en_q;
    assign shift_data = shift_data_q;
    assign gap_y      = gap_y_q;
    assign gap_valid  = gap_valid_q;
    assign running    = running_q;

endmodule

// File: tb/tb_pipe_scroll_controller.sv
// Directed bench for pipe_scroll_controller with a short divider and a 2-on/3-off pattern.
module tb_pipe_scroll_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic       shift_en;
    logic       shift_data;
    logic [6:0] gap_y;
    logic       gap_valid;
    logic       running;

    int checks = 0;
    int failures = 0;

    pipe_scroll_controller #(
        .DIV_BASE (16),
        .PIPE_W   (2),
        .SPACING  (3),
        .GAP_MIN  (10)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pause      (pause),
        .game_over  (game_over),
        .speed_sel  (speed_sel),
        .shift_en   (shift_en),
        .shift_data (shift_data),
        .gap_y      (gap_y),
        .gap_valid  (gap_valid),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int max, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            step();
            n++;
            if (shift_en === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        checks++;
        if ({shift_en, shift_data, gap_valid, running, gap_y} !== 11'd0) begin
            failures++;
            $display("FAIL reset_async: got %b expected all zero", {shift_en, shift_data, gap_valid, running, gap_y});
        end
        step();
        step();
        checks++;
        if ({shift_en, shift_data, gap_valid, running, gap_y} !== 11'd0) begin
            failures++;
            $display("FAIL reset_held: got %b expected all zero", {shift_en, shift_data, gap_valid, running, gap_y});
        end
        #2;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_flush();
        int good;
        good = 0;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (shift_en === 1'b1 && shift_data === 1'b0 && running === 1'b0) good++;
        end
        start = 1'b0;
        checks++;
        if (good != 40) begin
            failures++;
            $display("FAIL flush_strobes: got %0d good flush cycles expected 40", good);
        end
        step();
        checks++;
        if (running !== 1'b1 || shift_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_to_run: got running=%b shift_en=%b expected running=1 shift_en=0", running, shift_en);
        end
    endtask

    task automatic test_run_pattern();
        bit ed[7]   = '{1, 1, 0, 0, 0, 1, 1};
        bit eg[7]   = '{1, 0, 0, 0, 0, 1, 0};
        int egap[7] = '{20, 0, 0, 0, 0, 31, 0};
        int n;
        bit seen;
        for (int i = 0; i < 7; i++) begin
            wait_strobe(40, n, seen);
            checks++;
            if (!seen || n != ((i == 0) ? 16 : 15)) begin
                failures++;
                $display("FAIL run_spacing[%0d]: got %0d cycles seen=%0d expected %0d", i, n, seen, (i == 0) ? 16 : 15);
            end
            checks++;
            if (shift_data !== ed[i]) begin
                failures++;
                $display("FAIL run_data[%0d]: got %b expected %b", i, shift_data, ed[i]);
            end
            checks++;
            if (gap_valid !== eg[i]) begin
                failures++;
                $display("FAIL run_gap_valid[%0d]: got %b expected %b", i, gap_valid, eg[i]);
            end
            if (eg[i]) begin
                checks++;
                if (gap_y !== 7'(egap[i])) begin
                    failures++;
                    $display("FAIL run_gap_y[%0d]: got %0d expected %0d", i, gap_y, egap[i]);
                end
            end
            step();
            checks++;
            if (shift_en !== 1'b0 || gap_valid !== 1'b0) begin
                failures++;
                $display("FAIL run_one_cycle[%0d]: got shift_en=%b gap_valid=%b expected 0 0", i, shift_en, gap_valid);
            end
        end
    endtask

    task automatic test_speed_change();
        bit ed[5] = '{0, 0, 0, 1, 1};
        bit eg[5] = '{0, 0, 0, 1, 0};
        int n;
        bit seen;
        // Divider is at 1 here; move it to 10, past the faster period of 4.
        for (int k = 0; k < 9; k++) step();
        speed_sel = 2'd2;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                step();
                checks++;
                if (shift_en !== 1'b0) begin
                    failures++;
                    $display("FAIL speed_one_cycle[%0d]: got shift_en=%b expected 0", i, shift_en);
                end
            end
            wait_strobe(40, n, seen);
            checks++;
            if (!seen || n != ((i == 0) ? 1 : 3)) begin
                failures++;
                $display("FAIL speed_spacing[%0d]: got %0d cycles seen=%0d expected %0d", i, n, seen, (i == 0) ? 1 : 3);
            end
            checks++;
            if (shift_data !== ed[i] || gap_valid !== eg[i]) begin
                failures++;
                $display("FAIL speed_data[%0d]: got data=%b gv=%b expected data=%b gv=%b", i, shift_data, gap_valid, ed[i], eg[i]);
            end
            if (eg[i]) begin
                checks++;
                if (gap_y !== 7'd52 || gap_y < 7'd10 || gap_y > 7'd73) begin
                    failures++;
                    $display("FAIL speed_gap_y: got %0d expected 52 within 10..73", gap_y);
                end
            end
        end
    endtask

    task automatic test_pause();
        int n;
        int strobes;
        bit seen;
        speed_sel = 2'd0;
        wait_strobe(40, n, seen);
        checks++;
        if (!seen || n != 4 || shift_data !== 1'b0) begin
            failures++;
            $display("FAIL pause_pre_strobe: got %0d cycles seen=%0d data=%b expected 4 cycles data 0", n, seen, shift_data);
        end
        for (int k = 0; k < 7; k++) step();
        pause = 1'b1;
        step();
        checks++;
        if (running !== 1'b0 || shift_en !== 1'b0) begin
            failures++;
            $display("FAIL pause_enter: got running=%b shift_en=%b expected 0 0", running, shift_en);
        end
        strobes = 0;
        for (int k = 0; k < 99; k++) begin
            step();
            if (shift_en === 1'b1 || running === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            failures++;
            $display("FAIL pause_hold: got %0d active cycles expected 0", strobes);
        end
        pause = 1'b0;
        wait_strobe(40, n, seen);
        checks++;
        if (!seen || n != 9) begin
            failures++;
            $display("FAIL pause_resume: got %0d cycles seen=%0d expected 9", n, seen);
        end
        checks++;
        if (shift_data !== 1'b0 || running !== 1'b1) begin
            failures++;
            $display("FAIL pause_resume_state: got data=%b running=%b expected 0 1", shift_data, running);
        end
    endtask

    task automatic test_game_over();
        int n;
        int cnt;
        bit seen;
        wait_strobe(40, n, seen);
        checks++;
        if (!seen || n != 16 || shift_data !== 1'b0) begin
            failures++;
            $display("FAIL over_pre_strobe: got %0d cycles seen=%0d data=%b expected 16 cycles data 0", n, seen, shift_data);
        end
        for (int k = 0; k < 15; k++) step();
        game_over = 1'b1;
        step();
        checks++;
        if (shift_en !== 1'b0 || running !== 1'b0 || gap_valid !== 1'b0 || shift_data !== 1'b0 || gap_y !== 7'd52) begin
            failures++;
            $display("FAIL over_drop_tick: got en=%b run=%b gv=%b data=%b gap=%0d expected 0 0 0 0 52",
                     shift_en, running, gap_valid, shift_data, gap_y);
        end
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (shift_en === 1'b1 || running === 1'b1 || gap_y !== 7'd52) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            failures++;
            $display("FAIL over_hold: got %0d disturbed cycles expected 0", cnt);
        end
        game_over = 1'b0;
        start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (shift_en === 1'b1 && shift_data === 1'b0) cnt++;
        end
        start = 1'b0;
        checks++;
        if (cnt != 40) begin
            failures++;
            $display("FAIL over_reflush: got %0d flush strobes expected 40", cnt);
        end
        step();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL over_rerun: got running=%b expected 1", running);
        end
        wait_strobe(40, n, seen);
        checks++;
        if (!seen || n != 16 || shift_data !== 1'b1 || gap_valid !== 1'b1 || gap_y !== 7'd30) begin
            failures++;
            $display("FAIL over_first_pipe: got n=%0d data=%b gv=%b gap=%0d expected 16 1 1 30",
                     n, shift_data, gap_valid, gap_y);
        end
    endtask

    task automatic test_reset_mid_flush();
        int n;
        int cnt;
        bit seen;
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        start = 1'b1;
        step();
        checks++;
        if (shift_en !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush_start: got en=%b running=%b expected 1 0", shift_en, running);
        end
        for (int k = 0; k < 5; k++) step();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({shift_en, shift_data, gap_valid, running, gap_y} !== 11'd0) begin
            failures++;
            $display("FAIL rst_mid_flush: got %b expected all zero", {shift_en, shift_data, gap_valid, running, gap_y});
        end
        step();
        #2;
        resetn = 1'b1;
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (shift_en === 1'b1) cnt++;
        end
        start = 1'b0;
        step();
        checks++;
        if (cnt != 40 || running !== 1'b1) begin
            failures++;
            $display("FAIL rst_reflush: got %0d strobes running=%b expected 40 1", cnt, running);
        end
        wait_strobe(40, n, seen);
        checks++;
        if (!seen || n != 16 || gap_valid !== 1'b1 || gap_y !== 7'd20) begin
            failures++;
            $display("FAIL rst_lfsr_seed: got n=%0d gv=%b gap=%0d expected 16 1 20", n, gap_valid, gap_y);
        end
    endtask

    initial begin
        test_reset();
        test_flush();
        test_run_pattern();
        test_speed_change();
        test_pause();
        test_game_over();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
